// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared definitions for the key-driven LED controller.
//   mode_t     : 2-bit LED mode encoding seen on mode_out
//   next_mode  : the mode a single key press advances to (wraps FAST -> OFF)
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_ON         = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_OFF:        n = MODE_ON;
            MODE_ON:         n = MODE_BLINK_SLOW;
            MODE_BLINK_SLOW: n = MODE_BLINK_FAST;
            default:         n = MODE_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
// Two-flop synchronizer plus debounce for an active-low push key.
// Ports:
//   sys_clk     in   clock, rising edge
//   sys_rst     in   synchronous active-high reset
//   key_in      in   raw asynchronous key, pressed = 0
//   key_stable  out  debounced key level (idle = 1)
//   fall_pulse  out  one-cycle pulse when key_stable goes 1 -> 0
//   rise_pulse  out  one-cycle pulse when key_stable goes 0 -> 1
// ---------------------------------------------------------------------------
module key_filter #(
    parameter logic [19:0] CNT_DEBOUNCE = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_stable,
    output logic fall_pulse,
    output logic rise_pulse
);

    logic        sync1;
    logic        sync2;
    logic [19:0] deb_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            key_stable <= 1'b1;
            deb_cnt    <= '0;
            fall_pulse <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            // synchronizer stage
            sync1      <= key_in;
            sync2      <= sync1;
            fall_pulse <= 1'b0;
            rise_pulse <= 1'b0;
            // debounce stage: any sample matching the accepted level restarts the count
            if (sync2 == key_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_DEBOUNCE - 20'd1) begin
                deb_cnt    <= '0;
                key_stable <= sync2;
                fall_pulse <= ~sync2;
                rise_pulse <= sync2;
            end else begin
                deb_cnt <= deb_cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/key_led_ctrl.sv
// ---------------------------------------------------------------------------
// key_led_ctrl
// One push key cycles an LED through OFF -> ON -> BLINK_SLOW -> BLINK_FAST.
// Ports:
//   sys_clk      in   clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   key_in       in   raw asynchronous key, pressed = 0
//   led_out      out  LED drive, 1 = lit (registered)
//   mode_out     out  current mode, see led_ctrl_pkg::mode_t (registered)
//   press_pulse  out  one-cycle pulse per accepted mode-advance event (registered)
// Optional feature macro: KEY_LONGPRESS_EN
//   defined   : a press advances the mode on release; holding CNT_LONG cycles
//               forces OFF instead and that release is swallowed.
//   undefined : a press advances the mode on the debounced falling edge.
// ---------------------------------------------------------------------------
module key_led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [19:0] CNT_DEBOUNCE   = 20'd999_999,
    parameter logic [24:0] CNT_BLINK_SLOW = 25'd24_999_999,
    parameter logic [24:0] CNT_BLINK_FAST = 25'd4_999_999,
    parameter logic [26:0] CNT_LONG       = 27'd99_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic       led_out,
    output logic [1:0] mode_out,
    output logic       press_pulse
);

    logic        key_stable;
    logic        key_fall;
    logic        key_rise;
    mode_t       mode;
    logic        led;
    logic [24:0] blink_cnt;
    logic [24:0] blink_lim;

    key_filter #(
        .CNT_DEBOUNCE(CNT_DEBOUNCE)
    ) u_key_filter (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_stable (key_stable),
        .fall_pulse (key_fall),
        .rise_pulse (key_rise)
    );

    always_comb begin
        blink_lim = '0;
        case (mode)
            MODE_BLINK_SLOW: blink_lim = CNT_BLINK_SLOW - 25'd1;
            MODE_BLINK_FAST: blink_lim = CNT_BLINK_FAST - 25'd1;
            default:         blink_lim = '0;
        endcase
    end

`ifdef KEY_LONGPRESS_EN
    logic [26:0] long_cnt;
    logic        long_hit;
    logic        long_fire;
    logic        unused_key_fall;

    assign unused_key_fall = key_fall;
    // Fires on the CNT_LONG-th cycle of a stable-low key, at most once per press.
    assign long_fire = !key_stable && !long_hit && (long_cnt == CNT_LONG - 27'd1);
`else
    logic        long_fire;
    logic        unused_key_rise;

    assign unused_key_rise = key_rise;
    assign long_fire       = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode        <= MODE_OFF;
            led         <= 1'b0;
            blink_cnt   <= '0;
            press_pulse <= 1'b0;
`ifdef KEY_LONGPRESS_EN
            long_cnt    <= '0;
            long_hit    <= 1'b0;
`endif
        end else begin
            // press qualification stage
`ifdef KEY_LONGPRESS_EN
            press_pulse <= key_rise & ~long_hit;
            if (key_stable) begin
                long_cnt <= '0;
                long_hit <= 1'b0;
            end else if (!long_hit) begin
                if (long_fire) begin
                    long_hit <= 1'b1;
                    long_cnt <= '0;
                end else begin
                    long_cnt <= long_cnt + 27'd1;
                end
            end
`else
            press_pulse <= key_fall;
`endif
            // mode / blink stage; blinking is frozen while the key is held
            if (long_fire) begin
                mode      <= MODE_OFF;
                led       <= 1'b0;
                blink_cnt <= '0;
            end else if (press_pulse) begin
                mode      <= next_mode(mode);
                led       <= (next_mode(mode) != MODE_OFF);
                blink_cnt <= '0;
            end else if ((mode == MODE_BLINK_SLOW || mode == MODE_BLINK_FAST) && key_stable) begin
                if (blink_cnt == blink_lim) begin
                    led       <= ~led;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 25'd1;
                end
            end
        end
    end

    assign led_out  = led;
    assign mode_out = mode;

endmodule

// File: tb/tb_key_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_led_ctrl
// Directed and randomized key sequences against a behavioural model that
// works from the key sample history and elapsed-time arithmetic.
// ---------------------------------------------------------------------------
module tb_key_led_ctrl;

    localparam int D  = 4;
    localparam int LS = 8;
    localparam int LF = 2;
    localparam int LL = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       key_in;
    logic       led_out;
    logic [1:0] mode_out;
    logic       press_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int pp_seen  = 0;

    // model state
    bit [7:0] kh;        // kh[i] = key level sampled i edges ago
    bit       m_s;       // accepted key level
    bit       m_pend;    // accepted press event, shows on press_pulse next cycle
    bit       m_pp;
    int       m_mode;
    int       m_ticks;   // unfrozen cycles spent in the current blink mode
    int       m_low;
    bit       m_long;

    always #5 sys_clk = ~sys_clk;

    key_led_ctrl #(
        .CNT_DEBOUNCE   (20'd4),
        .CNT_BLINK_SLOW (25'd8),
        .CNT_BLINK_FAST (25'd2),
        .CNT_LONG       (27'd16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .led_out     (led_out),
        .mode_out    (mode_out),
        .press_pulse (press_pulse)
    );

    function automatic int exp_led();
        case (m_mode)
            0:       return 0;
            1:       return 1;
            2:       return ((m_ticks / LS) % 2 == 0) ? 1 : 0;
            default: return ((m_ticks / LF) % 2 == 0) ? 1 : 0;
        endcase
    endfunction

    task automatic model_edge(input bit k, input bit r);
        int nmode;
        int nt;
        int nlow;
        bit nlong;
        bit chg;
        if (r) begin
            kh = '1; m_s = 1; m_pend = 0; m_pp = 0;
            m_mode = 0; m_ticks = 0; m_low = 0; m_long = 0;
        end else begin
            nmode = m_mode; nt = m_ticks; nlow = m_low; nlong = m_long; chg = 1;
            if (m_pp) begin
                nmode = (m_mode + 1) % 4;
                nt = 0;
            end else if (m_mode >= 2 && m_s) begin
                nt = m_ticks + 1;
            end
`ifdef KEY_LONGPRESS_EN
            if (m_s) begin
                nlow = 0; nlong = 0;
            end else if (!m_long) begin
                nlow = m_low + 1;
                if (nlow == LL) begin
                    nlong = 1; nmode = 0; nt = 0;
                end
            end
`endif
            kh = {kh[6:0], k};
            // accepted once the D samples reaching the debouncer all disagree
            for (int i = 2; i < D + 2; i++)
                if (kh[i] == m_s) chg = 0;
            m_pp = m_pend;
`ifdef KEY_LONGPRESS_EN
            m_pend = chg && !m_s && !nlong;
`else
            m_pend = chg && m_s;
`endif
            if (chg) m_s = ~m_s;
            m_mode = nmode; m_ticks = nt; m_low = nlow; m_long = nlong;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input bit k, input bit r);
        key_in  = k;
        sys_rst = r;
        @(posedge sys_clk);
        model_edge(k, r);
        #1;
        check("mode_out", {30'd0, mode_out}, m_mode);
        check("led_out", {31'd0, led_out}, exp_led());
        check("press_pulse", {31'd0, press_pulse}, {31'd0, m_pp});
        if (press_pulse === 1'b1) pp_seen++;
    endtask

    task automatic press(input int hold, input int bounce, input int idle);
        for (int b = 0; b < bounce; b++) begin
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
            repeat ($urandom_range(1, 2)) step(1'b1, 1'b0);
        end
        repeat (hold) step(1'b0, 1'b0);
        for (int b = 0; b < bounce; b++) begin
            repeat ($urandom_range(1, 2)) step(1'b1, 1'b0);
            repeat ($urandom_range(1, 2)) step(1'b0, 1'b0);
        end
        repeat (idle) step(1'b1, 1'b0);
    endtask

    initial begin
        int exp_modes[4];
        exp_modes = '{1, 2, 3, 0};

        // reset with key held low, then release of reset with key still low
        repeat (3) step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);

        // bouncing press yields exactly one advance
        repeat (2) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        pp_seen = 0;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        check("debounce_pulses", pp_seen, 1);
        check("debounce_mode", {30'd0, mode_out}, 1);

        // mode wrap over four clean presses
        repeat (2) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            press(8, 0, 12);
            check("wrap_mode", {30'd0, mode_out}, exp_modes[p]);
        end
        check("wrap_led_off", {31'd0, led_out}, 0);

        // slow blink sustained, then fast blink entered mid-pattern
        press(8, 0, 10);
        press(8, 0, 40);
        press(6, 0, 21);
        press(6, 0, 15);

        // randomized presses with bounce, one mid-run reset
        for (int n = 0; n < 40; n++) begin
            press($urandom_range(2, 24), $urandom_range(0, 2), $urandom_range(3, 30));
            if (n == 20) begin
                repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
            end
        end

`ifdef KEY_LONGPRESS_EN
        // long hold from BLINK_FAST forces OFF without a release pulse
        repeat (2) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        repeat (3) press(8, 0, 12);
        check("long_start_mode", {30'd0, mode_out}, 3);
        pp_seen = 0;
        repeat (30) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        check("long_pulses", pp_seen, 0);
        check("long_mode", {30'd0, mode_out}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
